// File: rtl/estagio_id_ex.sv
// ID/EX pipeline register with RAW forwarding and ALU operand selection.
// Latency: one cycle from ID inputs to registered fields; forwarding/selection combinational.
// Backpressure: stall holds the stage, flush loads a bubble (flush wins); never stalls itself.
//
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   stall, flush           hold current contents / load a bubble
//   valid_in ... mem_write_in   decoded fields captured from ID
//   ex_mem_*, mem_wb_*     producer info used for operand forwarding
//   entrada1, entrada2, alu_control   ALU operands and opcode
//   valid_out, reg_write_out, mem_read_out, mem_write_out, rd_out   registered controls
//   dado_store             forwarded rt value (store data)
//   hazard_load            load-use stall request back to ID
module estagio_id_ex #(
    parameter int LARGURA     = 32,
    parameter int LARGURA_REG = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   valid_in,
    input  logic [LARGURA-1:0]     rs_dado,
    input  logic [LARGURA-1:0]     rt_dado,
    input  logic [LARGURA_REG-1:0] rs_end,
    input  logic [LARGURA_REG-1:0] rt_end,
    input  logic [LARGURA_REG-1:0] rd_end,
    input  logic [LARGURA-1:0]     imediato,
    input  logic [4:0]             shamt,
    input  logic                   usa_imediato,
    input  logic                   usa_shamt,
    input  logic [3:0]             alu_control_in,
    input  logic                   reg_write_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic                   ex_mem_reg_write,
    input  logic [LARGURA_REG-1:0] ex_mem_rd,
    input  logic [LARGURA-1:0]     ex_mem_resultado,
    input  logic                   mem_wb_reg_write,
    input  logic [LARGURA_REG-1:0] mem_wb_rd,
    input  logic [LARGURA-1:0]     mem_wb_dado,
    output logic [LARGURA-1:0]     entrada1,
    output logic [LARGURA-1:0]     entrada2,
    output logic [3:0]             alu_control,
    output logic                   valid_out,
    output logic                   reg_write_out,
    output logic                   mem_read_out,
    output logic                   mem_write_out,
    output logic [LARGURA_REG-1:0] rd_out,
    output logic [LARGURA-1:0]     dado_store,
    output logic                   hazard_load
);

    typedef struct packed {
        logic                   valid;
        logic [LARGURA-1:0]     rs_dado;
        logic [LARGURA-1:0]     rt_dado;
        logic [LARGURA_REG-1:0] rs_end;
        logic [LARGURA_REG-1:0] rt_end;
        logic [LARGURA_REG-1:0] rd_end;
        logic [LARGURA-1:0]     imediato;
        logic [4:0]             shamt;
        logic                   usa_imediato;
        logic                   usa_shamt;
        logic [3:0]             alu_control;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
    } id_ex_t;

    id_ex_t stage_q;
    id_ex_t stage_d;

    always_comb begin
        stage_d              = '0;
        stage_d.valid        = valid_in;
        stage_d.rs_dado      = rs_dado;
        stage_d.rt_dado      = rt_dado;
        stage_d.rs_end       = rs_end;
        stage_d.rt_end       = rt_end;
        stage_d.rd_end       = rd_end;
        stage_d.imediato     = imediato;
        stage_d.shamt        = shamt;
        stage_d.usa_imediato = usa_imediato;
        stage_d.usa_shamt    = usa_shamt;
        stage_d.alu_control  = alu_control_in;
        stage_d.reg_write    = reg_write_in;
        stage_d.mem_read     = mem_read_in;
        stage_d.mem_write    = mem_write_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (!stall) begin
            stage_q <= stage_d;
        end
    end

    // Youngest producer (EX/MEM) wins; register 0 is hardwired and never forwarded.
    function automatic logic [LARGURA-1:0] encaminha(
        input logic [LARGURA_REG-1:0] end_fonte,
        input logic [LARGURA-1:0]     dado_reg,
        input logic                   exm_wr,
        input logic [LARGURA_REG-1:0] exm_rd,
        input logic [LARGURA-1:0]     exm_res,
        input logic                   mwb_wr,
        input logic [LARGURA_REG-1:0] mwb_rd,
        input logic [LARGURA-1:0]     mwb_dado
    );
        logic [LARGURA-1:0] r;
        r = dado_reg;
        if (end_fonte != '0) begin
            if (exm_wr && (exm_rd == end_fonte)) begin
                r = exm_res;
            end else if (mwb_wr && (mwb_rd == end_fonte)) begin
                r = mwb_dado;
            end
        end
        return r;
    endfunction

    logic [LARGURA-1:0] fwd_rs;
    logic [LARGURA-1:0] fwd_rt;

    always_comb begin
        fwd_rs = encaminha(stage_q.rs_end, stage_q.rs_dado,
                           ex_mem_reg_write, ex_mem_rd, ex_mem_resultado,
                           mem_wb_reg_write, mem_wb_rd, mem_wb_dado);
        fwd_rt = encaminha(stage_q.rt_end, stage_q.rt_dado,
                           ex_mem_reg_write, ex_mem_rd, ex_mem_resultado,
                           mem_wb_reg_write, mem_wb_rd, mem_wb_dado);
    end

    always_comb begin
        entrada1    = '0;
        entrada2    = '0;
        dado_store  = '0;
        alu_control = 4'b0000;
        // A bubble presents all-zero operands so the ALU sees a harmless op.
        if (stage_q.valid) begin
            alu_control = stage_q.alu_control;
            dado_store  = fwd_rt;
            if (stage_q.usa_shamt) begin
                entrada1 = fwd_rt;
                entrada2 = {{(LARGURA-5){1'b0}}, stage_q.shamt};
            end else if (stage_q.usa_imediato) begin
                entrada1 = fwd_rs;
                entrada2 = stage_q.imediato;
            end else begin
                entrada1 = fwd_rs;
                entrada2 = fwd_rt;
            end
        end
    end

    assign valid_out     = stage_q.valid;
    assign reg_write_out = stage_q.reg_write;
    assign mem_read_out  = stage_q.mem_read;
    assign mem_write_out = stage_q.mem_write;
    assign rd_out        = stage_q.rd_end;

    // Load in EX whose destination is a source of the instruction now in ID.
    assign hazard_load = stage_q.valid && stage_q.mem_read && valid_in &&
                         (stage_q.rd_end != '0) &&
                         ((stage_q.rd_end == rs_end) || (stage_q.rd_end == rt_end));

endmodule

// File: tb/tb_estagio_id_ex.sv
module tb_estagio_id_ex;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, valid_in;
    logic [31:0] rs_dado, rt_dado, imediato;
    logic [4:0]  rs_end, rt_end, rd_end, shamt;
    logic        usa_imediato, usa_shamt;
    logic [3:0]  alu_control_in;
    logic        reg_write_in, mem_read_in, mem_write_in;
    logic        ex_mem_reg_write, mem_wb_reg_write;
    logic [4:0]  ex_mem_rd, mem_wb_rd;
    logic [31:0] ex_mem_resultado, mem_wb_dado;
    logic [31:0] entrada1, entrada2, dado_store;
    logic [3:0]  alu_control;
    logic        valid_out, reg_write_out, mem_read_out, mem_write_out, hazard_load;
    logic [4:0]  rd_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    estagio_id_ex #(.LARGURA(32), .LARGURA_REG(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .valid_in(valid_in),
        .rs_dado(rs_dado), .rt_dado(rt_dado), .rs_end(rs_end), .rt_end(rt_end),
        .rd_end(rd_end), .imediato(imediato), .shamt(shamt),
        .usa_imediato(usa_imediato), .usa_shamt(usa_shamt),
        .alu_control_in(alu_control_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_rd(ex_mem_rd),
        .ex_mem_resultado(ex_mem_resultado), .mem_wb_reg_write(mem_wb_reg_write),
        .mem_wb_rd(mem_wb_rd), .mem_wb_dado(mem_wb_dado),
        .entrada1(entrada1), .entrada2(entrada2), .alu_control(alu_control),
        .valid_out(valid_out), .reg_write_out(reg_write_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .rd_out(rd_out), .dado_store(dado_store), .hazard_load(hazard_load)
    );

    // Reference: what instruction the stage currently holds.
    typedef struct packed {
        logic        valid;
        logic [31:0] rs_dado, rt_dado, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        ui, us;
        logic [3:0]  alu;
        logic        rw, mr, mw;
    } entry_t;

    entry_t m;

    function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] regval);
        if (a == 0) return regval;
        if (ex_mem_reg_write && ex_mem_rd == a) return ex_mem_resultado;
        if (mem_wb_reg_write && mem_wb_rd == a) return mem_wb_dado;
        return regval;
    endfunction

    function automatic logic [31:0] exp_e1();
        if (!m.valid) return 0;
        return m.us ? fwd(m.rt, m.rt_dado) : fwd(m.rs, m.rs_dado);
    endfunction

    function automatic logic [31:0] exp_e2();
        if (!m.valid) return 0;
        if (m.us) return 32'(m.shamt);
        if (m.ui) return m.imm;
        return fwd(m.rt, m.rt_dado);
    endfunction

    function automatic logic [31:0] exp_store();
        return m.valid ? fwd(m.rt, m.rt_dado) : 32'd0;
    endfunction

    function automatic logic exp_hz();
        return m.valid && m.mr && valid_in && m.rd != 0 && (m.rd == rs_end || m.rd == rt_end);
    endfunction

    // Advance one clock, updating the reference with the capture priority.
    task automatic tick();
        if (flush) begin
            m = '0;
        end else if (!stall) begin
            m = '{valid: valid_in, rs_dado: rs_dado, rt_dado: rt_dado, imm: imediato,
                  rs: rs_end, rt: rt_end, rd: rd_end, shamt: shamt,
                  ui: usa_imediato, us: usa_shamt, alu: alu_control_in,
                  rw: reg_write_in, mr: mem_read_in, mw: mem_write_in};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; valid_in = 0;
        rs_dado = 0; rt_dado = 0; imediato = 0;
        rs_end = 0; rt_end = 0; rd_end = 0; shamt = 0;
        usa_imediato = 0; usa_shamt = 0; alu_control_in = 0;
        reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
        ex_mem_reg_write = 0; ex_mem_rd = 0; ex_mem_resultado = 0;
        mem_wb_reg_write = 0; mem_wb_rd = 0; mem_wb_dado = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        m = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (valid_out !== 1'b0 || alu_control !== 4'b0 || entrada1 !== 0 || entrada2 !== 0 || dado_store !== 0)
            begin fails++; $display("FAIL reset_init: valid=%0b alu=%h e1=%h e2=%h st=%h, want all 0", valid_out, alu_control, entrada1, entrada2, dado_store); end
        rst_n = 1;
        // Load a live instruction, then drop reset between edges.
        valid_in = 1; rs_end = 2; rs_dado = 32'hABCD; rt_end = 3; rt_dado = 32'h1234;
        rd_end = 9; alu_control_in = 4'h5; reg_write_in = 1; mem_read_in = 1; mem_write_in = 1;
        tick();
        tests++; if (entrada1 !== 32'hABCD || valid_out !== 1'b1)
            begin fails++; $display("FAIL reset_preload: e1=%h valid=%0b, want abcd 1", entrada1, valid_out); end
        #2 rst_n = 0;
        m = '0;
        #1;
        tests++; if ({valid_out, reg_write_out, mem_read_out, mem_write_out} !== 4'b0 || rd_out !== 0 ||
                     alu_control !== 0 || entrada1 !== 0 || entrada2 !== 0 || dado_store !== 0)
            begin fails++; $display("FAIL reset_async: ctl=%b rd=%0d alu=%h e1=%h e2=%h st=%h, want all 0",
                     {valid_out, reg_write_out, mem_read_out, mem_write_out}, rd_out, alu_control, entrada1, entrada2, dado_store); end
        #1 rst_n = 1;
        clear_inputs();
        tick();
    endtask

    task automatic test_raw();
        clear_inputs();
        valid_in = 1; rs_end = 3; rs_dado = 5; alu_control_in = 4'h2;
        tick();
        ex_mem_rd = 3; ex_mem_reg_write = 1; ex_mem_resultado = 32'h10;
        mem_wb_rd = 3; mem_wb_reg_write = 1; mem_wb_dado = 32'h20;
        #1;
        tests++; if (entrada1 !== 32'h10) begin fails++; $display("FAIL raw_exmem: e1=%h want 10", entrada1); end
        ex_mem_reg_write = 0;
        #1;
        tests++; if (entrada1 !== 32'h20) begin fails++; $display("FAIL raw_memwb: e1=%h want 20", entrada1); end
        mem_wb_reg_write = 0;
        #1;
        tests++; if (entrada1 !== 32'h5) begin fails++; $display("FAIL raw_regfile: e1=%h want 5", entrada1); end
    endtask

    task automatic test_reg0();
        clear_inputs();
        valid_in = 1; rs_end = 0; rs_dado = 0; rt_end = 0;
        tick();
        ex_mem_rd = 0; ex_mem_reg_write = 1; ex_mem_resultado = 32'hFFFF;
        mem_wb_rd = 0; mem_wb_reg_write = 1; mem_wb_dado = 32'h1111;
        #1;
        tests++; if (entrada1 !== 0 || entrada2 !== 0)
            begin fails++; $display("FAIL reg0: e1=%h e2=%h want 0 0", entrada1, entrada2); end
    endtask

    task automatic test_shift();
        clear_inputs();
        valid_in = 1; usa_shamt = 1; usa_imediato = 1; shamt = 4; imediato = 32'h55;
        rt_end = 2; rt_dado = 9; rs_end = 6; rs_dado = 32'h66; alu_control_in = 4'b1000;
        tick();
        ex_mem_rd = 2; ex_mem_reg_write = 1; ex_mem_resultado = 32'h1;
        #1;
        tests++; if (entrada1 !== 32'h1 || entrada2 !== 32'h4 || alu_control !== 4'b1000 || dado_store !== 32'h1)
            begin fails++; $display("FAIL shift: e1=%h e2=%h alu=%b st=%h want 1 4 1000 1", entrada1, entrada2, alu_control, dado_store); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        valid_in = 1; mem_read_in = 1; reg_write_in = 1; rd_end = 7; rs_end = 1; rs_dado = 32'h40;
        tick();
        clear_inputs();
        valid_in = 1; rt_end = 7; rs_end = 1;
        #1;
        tests++; if (hazard_load !== 1'b1) begin fails++; $display("FAIL load_use_hz: hz=%0b want 1", hazard_load); end
        valid_in = 0;
        #1;
        tests++; if (hazard_load !== 1'b0) begin fails++; $display("FAIL load_use_noid: hz=%0b want 0", hazard_load); end
        valid_in = 1; rt_end = 5; rs_end = 7;
        #1;
        tests++; if (hazard_load !== 1'b1) begin fails++; $display("FAIL load_use_rs: hz=%0b want 1", hazard_load); end
        stall = 1; flush = 1;
        tick();
        stall = 0; flush = 0;
        #1;
        tests++; if (valid_out !== 0 || entrada1 !== 0 || entrada2 !== 0 || hazard_load !== 0 || mem_read_out !== 0)
            begin fails++; $display("FAIL load_use_flush: valid=%0b e1=%h e2=%h hz=%0b mr=%0b want 0", valid_out, entrada1, entrada2, hazard_load, mem_read_out); end
    endtask

    task automatic test_stall_hold();
        clear_inputs();
        valid_in = 1; usa_imediato = 1; imediato = 32'hFFFF_FFF0; rs_end = 4; rs_dado = 32'h11;
        alu_control_in = 4'h2; rd_end = 8; reg_write_in = 1;
        tick();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1; rs_dado = $urandom; rt_dado = $urandom; imediato = $urandom;
            rs_end = 5'($urandom); rt_end = 5'($urandom); rd_end = 5'($urandom);
            alu_control_in = 4'($urandom); usa_shamt = 1'($urandom);
            tick();
            tests++; if (entrada1 !== 32'h11 || entrada2 !== 32'hFFFF_FFF0 || alu_control !== 4'h2 || rd_out !== 5'd8 || reg_write_out !== 1'b1)
                begin fails++; $display("FAIL stall_hold[%0d]: e1=%h e2=%h alu=%h rd=%0d rw=%0b", i, entrada1, entrada2, alu_control, rd_out, reg_write_out); end
        end
        mem_wb_rd = 4; mem_wb_reg_write = 1; mem_wb_dado = 32'h77;
        #1;
        tests++; if (entrada1 !== 32'h77) begin fails++; $display("FAIL stall_fwd: e1=%h want 77", entrada1); end
        tick();
        tests++; if (entrada1 !== 32'h77 || entrada2 !== 32'hFFFF_FFF0)
            begin fails++; $display("FAIL stall_fwd_hold: e1=%h e2=%h want 77 fffffff0", entrada1, entrada2); end
        stall = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 7) == 0);
            valid_in = ($urandom_range(0, 3) != 0);
            rs_dado = $urandom; rt_dado = $urandom; imediato = $urandom;
            rs_end = 5'($urandom_range(0, 3)); rt_end = 5'($urandom_range(0, 3));
            rd_end = 5'($urandom_range(0, 3)); shamt = 5'($urandom);
            usa_imediato = 1'($urandom); usa_shamt = ($urandom_range(0, 3) == 0);
            alu_control_in = 4'($urandom);
            reg_write_in = 1'($urandom); mem_read_in = 1'($urandom); mem_write_in = 1'($urandom);
            tick();
            ex_mem_reg_write = 1'($urandom); ex_mem_rd = 5'($urandom_range(0, 3)); ex_mem_resultado = $urandom;
            mem_wb_reg_write = 1'($urandom); mem_wb_rd = 5'($urandom_range(0, 3)); mem_wb_dado = $urandom;
            valid_in = 1'($urandom); rs_end = 5'($urandom_range(0, 3)); rt_end = 5'($urandom_range(0, 3));
            #1;
            tests++;
            if (entrada1 !== exp_e1() || entrada2 !== exp_e2() || dado_store !== exp_store() ||
                alu_control !== (m.valid ? m.alu : 4'h0) || hazard_load !== exp_hz() ||
                valid_out !== m.valid || rd_out !== m.rd ||
                {reg_write_out, mem_read_out, mem_write_out} !== {m.rw, m.mr, m.mw}) begin
                fails++;
                $display("FAIL random[%0d]: e1=%h/%h e2=%h/%h st=%h/%h alu=%h hz=%0b/%0b v=%0b/%0b rd=%0d/%0d",
                         i, entrada1, exp_e1(), entrada2, exp_e2(), dado_store, exp_store(),
                         alu_control, hazard_load, exp_hz(), valid_out, m.valid, rd_out, m.rd);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_raw();
        test_reg0();
        test_shift();
        test_load_use();
        test_stall_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/estagio_id_ex.md
Name: estagio_id_ex

Overview:
- ID/EX pipeline register plus operand-forwarding/selection logic; sits directly upstream of the ALU and drives its entrada1, entrada2 and alu_control.
- Captures decoded fields each cycle, resolves RAW hazards from EX/MEM and MEM/WB, selects immediate or shamt operands, and flags load-use hazards back to the decode stage.

Parameters:
- LARGURA, 32, datapath width.
- LARGURA_REG, 5, register-address width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold the current stage contents.
- flush  input  1  replace the next captured entry with a bubble.
- valid_in  input  1  the ID stage holds a real instruction.
- rs_dado, rt_dado  input  LARGURA  register-file read data.
- rs_end, rt_end, rd_end  input  LARGURA_REG  source and destination addresses.
- imediato  input  LARGURA  sign-extended immediate.
- shamt  input  5  shift amount.
- usa_imediato, usa_shamt  input  1  operand-select controls.
- alu_control_in  input  4  ALU opcode from decode.
- reg_write_in, mem_read_in, mem_write_in  input  1  control bits carried forward.
- ex_mem_reg_write  input  1  EX/MEM stage will write a register.
- ex_mem_rd  input  LARGURA_REG  EX/MEM destination address.
- ex_mem_resultado  input  LARGURA  EX/MEM result.
- mem_wb_reg_write  input  1  MEM/WB stage will write a register.
- mem_wb_rd  input  LARGURA_REG  MEM/WB destination address.
- mem_wb_dado  input  LARGURA  MEM/WB writeback data.
- entrada1, entrada2  output  LARGURA  ALU operands.
- alu_control  output  4  ALU opcode.
- valid_out, reg_write_out, mem_read_out, mem_write_out  output  1  registered control bits.
- rd_out  output  LARGURA_REG  registered destination address.
- dado_store  output  LARGURA  forwarded rt value, used as store data.
- hazard_load  output  1  load-use stall request to ID.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - All stage registers clear to 0, so valid_out=0 and every control bit is 0.
  - alu_control=4'b0000; entrada1, entrada2 and dado_store read 0.
- Capture priority at each rising edge: flush, then stall, then normal load.
  - flush=1: load a bubble (every field 0). Flush wins over stall.
  - stall=1 (and flush=0): hold every register.
  - Otherwise: load all ID inputs; the stored valid bit takes valid_in.
- Latency: one cycle from ID inputs to registered outputs. Forwarding and operand selection are combinational on the registered fields plus the live forwarding inputs.
- Forwarding, evaluated separately for rs and rt (registered addresses):
  - Address 0 never forwards; the value is the registered register-file data (0).
  - Use EX/MEM when ex_mem_reg_write=1 and ex_mem_rd matches the address.
  - Otherwise use MEM/WB when mem_wb_reg_write=1 and mem_wb_rd matches.
  - Otherwise use the registered register-file data.
  - When both stages match, EX/MEM wins.
- Forwarding while stalled: it is re-evaluated every cycle, so a held instruction picks up newly arriving producer values.
- Operand selection:
  - usa_shamt=1: entrada1 = forwarded rt; entrada2 = shamt zero-extended to LARGURA. usa_shamt takes priority over usa_imediato.
  - usa_imediato=1: entrada1 = forwarded rs; entrada2 = imediato.
  - Otherwise: entrada1 = forwarded rs; entrada2 = forwarded rt.
  - dado_store is always the forwarded rt.
- Bubble (stored valid bit 0): entrada1, entrada2 and dado_store are forced to 0 and alu_control to 4'b0000, regardless of forwarding.
- hazard_load (combinational) = 1 when all of the following hold:
  - stored valid bit, mem_read_out and valid_in are all 1;
  - rd_out != 0;
  - rd_out equals rs_end or rt_end.
- hazard_load has no internal effect; the stage never stalls itself. Decode is expected to assert stall and flush in response.

Test Plan:
- Reset mid-operation: load an instruction, drop rst_n between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
- Back-to-back RAW: capture rs=3 with rs_dado=5; ex_mem_rd=3, ex_mem_reg_write=1, ex_mem_resultado=32'h10; mem_wb_rd=3, mem_wb_reg_write=1, mem_wb_dado=32'h20 -> entrada1=32'h10. Deassert ex_mem_reg_write -> entrada1=32'h20.
- Register 0: rs=0, ex_mem_rd=0, ex_mem_reg_write=1, ex_mem_resultado=32'hFFFF -> entrada1=0.
- Shift: usa_shamt=1, shamt=4, rt forwarded 32'h1, alu_control_in=4'b1000 -> entrada1=1, entrada2=4, alu_control=4'b1000.
- Load-use: registered lw with rd=7; valid_in=1, rt_end=7 -> hazard_load=1. Assert stall and flush together -> next cycle valid_out=0, entradas 0, hazard_load=0.
- Stall hold: immediate op with imediato=32'hFFFF_FFF0 loaded, then stall=1 for 3 cycles while the ID inputs change -> outputs unchanged. Forward value changes during the stall -> entrada1 tracks it.
